// File: rtl/uart_rx_fifo.sv
// Receive buffer between the UART receiver and the CPU read mux: first-word-fall-through
// FIFO with a sticky overflow flag and hysteretic CTS flow control.
module uart_rx_fifo #(
  parameter  int WIDTH      = 8,
  parameter  int DEPTH      = 16,
  parameter  int HIGH_WATER = 12,
  parameter  int LOW_WATER  = 4,
  localparam int CW         = $clog2(DEPTH + 1),
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             pop,
  input  logic             clr_overflow,
  output logic [WIDTH-1:0] rd_data,
  output logic             not_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             cts
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] HIGH_CNT = CW'(HIGH_WATER);
  localparam logic [CW-1:0] LOW_CNT  = CW'(LOW_WATER);

  typedef enum logic {
    CTS_SEND,
    CTS_HOLD
  } cts_state_e;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  cts_state_e       state_q, state_d;

  logic pop_ok;
  logic push_ok;
  logic drop;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
  assign pop_ok  = pop && (count_q != '0);
  assign push_ok = rx_valid && ((count_q != FULL_CNT) || pop_ok);
  assign drop    = rx_valid && !push_ok;

  // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    state_d    = state_q;

    if (push_ok) wp_d = wp_q + AW'(1);
    if (pop_ok)  rp_d = rp_q + AW'(1);

    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A new drop takes priority over a clear in the same cycle.
    if (drop)              overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;

    unique case (state_q)
      CTS_SEND: if (count_d >= HIGH_CNT) state_d = CTS_HOLD;
      CTS_HOLD: if (count_d <= LOW_CNT)  state_d = CTS_SEND;
      default:  state_d = CTS_SEND;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= CTS_SEND;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
    end
  end

  // NOTE: storage is deliberately not reset; count gates rd_data, so stale entries are never seen.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wp_q] <= rx_data;
  end

  always_comb begin
    rd_data = '0;
    if (count_q != '0) rd_data = mem_q[rp_q];
  end

  assign not_empty = (count_q != '0);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign cts       = (state_q == CTS_SEND);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: stimulus queues expected bytes, a negedge monitor
// compares rd_data on every accepted pop, and direct checks cover count/flags/cts.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       pop;
  logic       clr_overflow;
  logic [7:0] rd_data;
  logic       not_empty;
  logic [4:0] count;
  logic       overflow;
  logic       cts;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] sb[$];

  uart_rx_fifo #(
    .WIDTH(8), .DEPTH(16), .HIGH_WATER(12), .LOW_WATER(4)
  ) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .pop(pop),
    .clr_overflow(clr_overflow), .rd_data(rd_data), .not_empty(not_empty),
    .count(count), .overflow(overflow), .cts(cts)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: the CPU samples rd_data in the cycle it pops a non-empty FIFO.
  always @(negedge clk) begin
    if (!rst && pop && not_empty) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL pop_unexpected: got 0x%0h expected no data", rd_data);
      end else begin
        check("pop_data", 32'(rd_data), 32'(sb.pop_front()));
      end
    end
  end

  // One clock of stimulus; returns 1 ns after the edge so outputs reflect it.
  task automatic cycle(input logic rv, input logic [7:0] d, input logic p, input logic clr);
    rx_valid     = rv;
    rx_data      = d;
    pop          = p;
    clr_overflow = clr;
    @(posedge clk);
    #1;
    rx_valid     = 1'b0;
    pop          = 1'b0;
    clr_overflow = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic expect_accept);
    if (expect_accept) sb.push_back(d);
    cycle(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic pop_n(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; pop = 1'b0; clr_overflow = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_count", 32'(count), 0);
    check("rst_not_empty", 32'(not_empty), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_cts", 32'(cts), 1);

    // Single byte through an empty FIFO.
    push(8'hA5, 1'b1);
    check("single_not_empty", 32'(not_empty), 1);
    check("single_count", 32'(count), 1);
    check("single_rd_data", 32'(rd_data), 32'hA5);
    pop_n(1);
    check("single_pop_count", 32'(count), 0);
    check("single_pop_not_empty", 32'(not_empty), 0);
    check("single_pop_rd_data", 32'(rd_data), 0);

    // Ordering and pointer wrap: 40 bytes, steady occupancy of 8.
    for (int i = 0; i < 40; i++) begin
      sb.push_back(8'(i));
      cycle(1'b1, 8'(i), (i >= 8), 1'b0);
    end
    check("wrap_count", 32'(count), 8);
    pop_n(8);
    check("wrap_drained", 32'(count), 0);
    check("wrap_overflow", 32'(overflow), 0);
    check("wrap_cts", 32'(cts), 1);

    // Fill to DEPTH, then drop one byte.
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i), 1'b1);
    check("full_count", 32'(count), 16);
    check("full_overflow_clear", 32'(overflow), 0);
    check("full_cts", 32'(cts), 0);
    push(8'h20, 1'b0);
    check("drop_overflow", 32'(overflow), 1);
    check("drop_count", 32'(count), 16);
    cycle(1'b1, 8'h77, 1'b0, 1'b1);
    check("set_wins_overflow", 32'(overflow), 1);
    check("set_wins_count", 32'(count), 16);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_overflow", 32'(overflow), 0);

    // Full plus simultaneous push and pop.
    sb.push_back(8'h55);
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    check("full_both_count", 32'(count), 16);
    check("full_both_overflow", 32'(overflow), 0);
    pop_n(16);
    check("full_drained", 32'(count), 0);
    check("full_drained_cts", 32'(cts), 1);
    pop_n(1);
    check("empty_pop_count", 32'(count), 0);
    check("empty_pop_overflow", 32'(overflow), 0);

    // Empty plus simultaneous push and pop.
    sb.push_back(8'h66);
    cycle(1'b1, 8'h66, 1'b1, 1'b0);
    check("empty_both_count", 32'(count), 1);
    check("empty_both_rd_data", 32'(rd_data), 32'h66);
    pop_n(1);

    // CTS hysteresis.
    for (int i = 0; i < 11; i++) push(8'(8'h80 + i), 1'b1);
    check("cts_at11_count", 32'(count), 11);
    check("cts_at11", 32'(cts), 1);
    push(8'h8B, 1'b1);
    check("cts_at12", 32'(cts), 0);
    pop_n(7);
    check("cts_at5_count", 32'(count), 5);
    check("cts_at5", 32'(cts), 0);
    pop_n(1);
    check("cts_at4", 32'(cts), 1);

    // Reset mid-stream at count 9 with cts low.
    for (int i = 0; i < 8; i++) push(8'(8'h90 + i), 1'b1);
    pop_n(3);
    check("mid_count", 32'(count), 9);
    check("mid_cts", 32'(cts), 0);
    rst = 1'b1;
    cycle(1'b1, 8'hEE, 1'b1, 1'b0);
    rst = 1'b0;
    sb.delete();
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_cts", 32'(cts), 1);
    check("mid_rst_overflow", 32'(overflow), 0);
    check("mid_rst_not_empty", 32'(not_empty), 0);

    push(8'h3C, 1'b1);
    check("post_rst_rd_data", 32'(rd_data), 32'h3C);
    pop_n(1);
    check("post_rst_count", 32'(count), 0);
    check("scoreboard_empty", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised receive buffer between the buart receiver and the CPU I/O read mux. It replaces the single-byte UART latch and its valid flag with a DEPTH-entry first-word-fall-through FIFO. It adds hysteretic CTS flow control, a sticky overflow flag and a packed status word for the misc.in I/O slot. One instance is used per UART channel.

Parameters:
WIDTH, 8, data bits per entry (buart rx_data width).
DEPTH, 16, number of entries; power of two, 2..256.
HIGH_WATER, 12, cts drops when count >= HIGH_WATER; must satisfy LOW_WATER < HIGH_WATER <= DEPTH.
LOW_WATER, 4, cts reasserts when count <= LOW_WATER.

Ports:
clk  in  1  system clock (PLL output).
rst  in  1  reset, synchronous, active-high.
rx_valid  in  1  one-cycle strobe from buart: rx_data holds a received byte.
rx_data  in  WIDTH  received byte.
pop  in  1  CPU read of the UART RX data address (io_read_enable & address bit); removes the head entry.
clr_overflow  in  1  clears the sticky overflow flag.
rd_data  out  WIDTH  head entry; valid when not_empty=1, else 0.
not_empty  out  1  FIFO holds at least one entry.
count  out  CW  occupancy, 0..DEPTH; CW = $clog2(DEPTH+1).
overflow  out  1  sticky: a byte was dropped because the FIFO was full.
cts  out  1  1 = remote may send; drives the CTS pin.

Behaviour:
- Reset (rst=1 at a clk edge): the next cycle shows count=0, not_empty=0, rd_data=0, overflow=0, cts=1. Read and write pointers go to 0. Storage contents are don't-care.
- Reset mid-stream: all buffered bytes are discarded. rx_valid and pop in the reset cycle are ignored.
- Storage: WIDTH x DEPTH array. Write pointer wp and read pointer rp are $clog2(DEPTH) bits and wrap modulo DEPTH naturally. Occupancy is tracked in a separate count register, so full and empty are unambiguous.
- Push: rx_valid=1 and (count<DEPTH or pop accepted in the same cycle) -> mem[wp]<=rx_data, wp<=wp+1.
- Pop: pop=1 and count>0 -> rp<=rp+1. pop when empty is ignored: no pointer change, no flag.
- Count update:
  - push only: +1.
  - pop only: -1.
  - both: unchanged.
  - neither: unchanged.
- Full plus simultaneous push and pop: both are accepted, count stays DEPTH, and no overflow is raised.
- Empty plus simultaneous push and pop: the pop is ignored and the push is accepted, so count becomes 1.
- Overflow: rx_valid=1, count=DEPTH and no pop -> the byte is dropped and overflow<=1 next cycle.
  - overflow holds until clr_overflow=1 or reset.
  - If clr_overflow and a new drop occur in the same cycle, set wins.
- FWFT latency:
  - rd_data = mem[rp] whenever count>0. A byte pushed into an empty FIFO appears on rd_data with not_empty=1 one cycle after the rx_valid strobe.
  - After an accepted pop, rd_data shows the next entry in the following cycle.
  - not_empty = (count != 0), derived from the count register with no extra delay.
- The CPU samples rd_data in the same cycle it asserts pop. The top-level io_read_data register captures the value before the pointer advances.
- CTS hysteresis is a registered 2-state FSM:
  - SEND (cts=1) -> HOLD when the next count >= HIGH_WATER.
  - HOLD (cts=0) -> SEND when the next count <= LOW_WATER.
  - cts changes in the same cycle count crosses the threshold. There is no toggling for counts between the two thresholds.
- Status packing is done by the top level, MSB to LSB: {count, overflow, not_empty}.
- No combinational path from rx_valid or pop to any output.

Test Plan:
- Reset, then a single byte: rst 1 cycle; rx_valid with 0xA5 -> next cycle not_empty=1, count=1, rd_data=0xA5; pop -> next cycle count=0, not_empty=0, rd_data=0.
- Ordering and wrap: push 0x00..0x27 (40 bytes) interleaved with pops so count never exceeds 10 -> popped sequence is exactly 0x00..0x27; pointers wrap twice; overflow=0.
- Full and overflow: push 17 bytes 0x10..0x20 with no pop (DEPTH=16) -> count=16, overflow=1 after the 17th strobe; pop returns 0x10..0x1F, and 0x20 is never seen. clr_overflow -> overflow=0.
- Simultaneous events:
  - at count=16, push 0x55 plus pop -> count stays 16, overflow=0, 0x55 is the last byte popped.
  - at count=0, push 0x66 plus pop -> count=1, rd_data=0x66.
- CTS hysteresis: push to count=11 -> cts=1; 12th push -> cts=0 that cycle; pop down to 5 -> cts still 0; pop to 4 -> cts=1.
- Reset mid-stream: count=9 and cts=0, assert rst together with rx_valid and pop -> next cycle count=0, cts=1, overflow=0, not_empty=0.
